t48_cond_branch_gen: RTL

//  Parametrised branch-condition evaluator for the T48-family CPU cores. It sits between the decoder and the program counter.

---
 rtl/t48_cond_branch_gen_if.sv | 41 ++++
 rtl/t48_cond_branch_gen.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/t48_cond_branch_gen_if.sv
// Bus bundle between the T48 decoder/PC side (master) and the branch-condition
// evaluator (slave).
//   master : drives evaluation request, condition code, operands, pins, flags;
//            receives the decision, valid pulse, timer-flag clear and DJNZ result.
//   slave  : the mirror view, used by t48_cond_branch_gen.
interface t48_cond_branch_gen_if #(
    parameter int unsigned ACC_W = 8,
    parameter int unsigned NUM_T = 2,
    parameter int unsigned NUM_F = 2,
    parameter int unsigned SEL_W = 3
);
    logic             en_clk_i;
    logic             compute_take_i;
    logic [3:0]       branch_cond_i;
    logic [SEL_W-1:0] sel_i;
    logic             pol_i;
    logic [ACC_W-1:0] accu_i;
    logic [ACC_W-1:0] reg_val_i;
    logic [NUM_T-1:0] t_i;
    logic             int_n_i;
    logic [NUM_F-1:0] f_i;
    logic             carry_i;
    logic             tf_i;
    logic             take_branch_o;
    logic             take_valid_o;
    logic             tf_clr_o;
    logic [ACC_W-1:0] dec_o;
    logic             dec_we_o;

    modport master (
        output en_clk_i, compute_take_i, branch_cond_i, sel_i, pol_i, accu_i, reg_val_i,
               t_i, int_n_i, f_i, carry_i, tf_i,
        input  take_branch_o, take_valid_o, tf_clr_o, dec_o, dec_we_o
    );

    modport slave (
        input  en_clk_i, compute_take_i, branch_cond_i, sel_i, pol_i, accu_i, reg_val_i,
               t_i, int_n_i, f_i, carry_i, tf_i,
        output take_branch_o, take_valid_o, tf_clr_o, dec_o, dec_we_o
    );
endinterface

// File: rtl/t48_cond_branch_gen.sv
// Branch-condition evaluator for T48-family cores, between decoder and PC.
// Ports:
//   clk_i  : system clock, rising edge
//   res_i  : synchronous active-high reset
//   bus    : t48_cond_branch_gen_if.slave (request, operands, pins, flags in;
//            take_branch_o / take_valid_o / tf_clr_o / dec_o / dec_we_o out)
// Optional feature: define T48_CB_INT_LATCH_EN to make code 4 test a sticky
// interrupt-pending latch set on the falling edge of the synchronised INT line.
module t48_cond_branch_gen #(
    parameter int unsigned ACC_W       = 8,
    parameter int unsigned NUM_T       = 2,
    parameter int unsigned NUM_F       = 2,
    parameter int unsigned SEL_W       = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                  clk_i,
    input logic                  res_i,
    t48_cond_branch_gen_if.slave bus
);

    // Synchronisers run every clk, independent of the machine-cycle enable.
    logic [NUM_T-1:0]       t_sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] int_sync_q;
    logic [NUM_T-1:0]       t_s;
    logic                   int_s;

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) t_sync_q[i] <= '0;
            int_sync_q <= '0;
        end else begin
            t_sync_q[0]   <= bus.t_i;
            int_sync_q[0] <= bus.int_n_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                t_sync_q[i]   <= t_sync_q[i-1];
                int_sync_q[i] <= int_sync_q[i-1];
            end
        end
    end

    assign t_s   = t_sync_q[SYNC_STAGES-1];
    assign int_s = int_sync_q[SYNC_STAGES-1];

    logic fire;
    assign fire = bus.en_clk_i & bus.compute_take_i;

`ifdef T48_CB_INT_LATCH_EN
    logic int_prev_q;
    logic int_pend_q;
    logic int_clr;

    // Only a taken code 4 consumes the pending interrupt.
    assign int_clr = fire & (bus.branch_cond_i == 4'd4) & int_pend_q;

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            int_prev_q <= 1'b0;
            int_pend_q <= 1'b0;
        end else begin
            int_prev_q <= int_s;
            // Set term is OR-ed last so a coincident edge wins over the clear.
            int_pend_q <= (int_pend_q & ~int_clr) | (int_prev_q & ~int_s);
        end
    end
`endif

    // Indexed bit selects; out-of-range indices leave the bit at 0.
    logic acc_bit;
    logic f_bit;
    logic t_bit;
    logic t_hit;
    logic take;

    always_comb begin
        acc_bit = 1'b0;
        f_bit   = 1'b0;
        t_bit   = 1'b0;
        t_hit   = 1'b0;
        for (int i = 0; i < ACC_W; i++) begin
            if (bus.sel_i == SEL_W'(i)) acc_bit = bus.accu_i[i];
        end
        for (int i = 0; i < NUM_F; i++) begin
            if (bus.sel_i == SEL_W'(i)) f_bit = bus.f_i[i];
        end
        for (int i = 0; i < NUM_T; i++) begin
            if (bus.sel_i == SEL_W'(i)) begin
                t_bit = t_s[i];
                t_hit = 1'b1;
            end
        end

        take = 1'b0;
        case (bus.branch_cond_i)
            4'd0: take = acc_bit;
            4'd1: take = ((bus.accu_i == '0) == bus.pol_i);
            4'd2: take = (bus.carry_i == bus.pol_i);
            4'd3: take = f_bit;
`ifdef T48_CB_INT_LATCH_EN
            4'd4: take = int_pend_q;
`else
            4'd4: take = ~int_s;
`endif
            4'd5: take = t_hit & (t_bit == bus.pol_i);
            4'd6: take = bus.tf_i;
            4'd7: take = 1'b1;
            4'd8: take = (bus.reg_val_i != ACC_W'(1));
            default: take = 1'b0;
        endcase
    end

    logic             take_q;
    logic             valid_q;
    logic             tf_clr_q;
    logic [ACC_W-1:0] dec_q;
    logic             dec_we_q;

    // Pulses are recomputed every clk so they last exactly one cycle; the
    // decision and DJNZ result only change on an enabled evaluation.
    always_ff @(posedge clk_i) begin
        if (res_i) begin
            take_q   <= 1'b0;
            valid_q  <= 1'b0;
            tf_clr_q <= 1'b0;
            dec_q    <= '0;
            dec_we_q <= 1'b0;
        end else begin
            valid_q  <= fire;
            tf_clr_q <= fire & (bus.branch_cond_i == 4'd6) & bus.tf_i;
            dec_we_q <= fire & (bus.branch_cond_i == 4'd8);
            if (fire) take_q <= take;
            if (fire && (bus.branch_cond_i == 4'd8)) dec_q <= bus.reg_val_i - ACC_W'(1);
        end
    end

    assign bus.take_branch_o = take_q;
    assign bus.take_valid_o  = valid_q;
    assign bus.tf_clr_o      = tf_clr_q;
    assign bus.dec_o         = dec_q;
    assign bus.dec_we_o      = dec_we_q;

endmodule
